// File: rtl/fir_out_buffer_if.sv
// Ready/valid stream carrying buffered FIR samples to a downstream consumer.
interface fir_out_buffer_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/fir_out_buffer.sv
// Captures a backpressure-free FIR output stream into a small FIFO and replays it
// on a ready/valid master port; counts samples lost when the FIFO is full.
module fir_out_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid_in,
  input  logic [DATA_WIDTH-1:0]      i_data_in,
  fir_out_buffer_if.master           m_if,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_overflow,
  output logic [CNT_WIDTH-1:0]       o_drop_count,
  input  logic                       i_clear_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0]        LVL_FULL = LW'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_rd_ptr;
  logic [AW-1:0]         r_wr_ptr;
  logic [LW-1:0]         r_level;
  logic                  r_overflow;
  logic [CNT_WIDTH-1:0]  r_drop_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_accept;
  logic w_drop;

  assign w_empty  = (r_level == {LW{1'b0}});
  assign w_full   = (r_level == LVL_FULL);
  assign w_pop    = !w_empty && m_if.m_ready;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign w_accept = i_valid_in && (!w_full || w_pop);
  assign w_drop   = i_valid_in && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= i_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= {AW{1'b0}};
      r_wr_ptr <= {AW{1'b0}};
      r_level  <= {LW{1'b0}};
    end else begin
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      case ({w_accept, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // A drop on the same edge as clear_ovf wins and restarts the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow   <= 1'b0;
      r_drop_count <= {CNT_WIDTH{1'b0}};
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (i_clear_ovf) begin
        r_drop_count <= CNT_WIDTH'(1);
      end else if (r_drop_count != CNT_MAX) begin
        r_drop_count <= r_drop_count + CNT_WIDTH'(1);
      end else begin
        r_drop_count <= r_drop_count;
      end
    end else if (i_clear_ovf) begin
      r_overflow   <= 1'b0;
      r_drop_count <= {CNT_WIDTH{1'b0}};
    end else begin
      r_overflow   <= r_overflow;
      r_drop_count <= r_drop_count;
    end
  end

  always_comb begin
    m_if.m_valid = !w_empty;
    m_if.m_data  = {DATA_WIDTH{1'b0}};
    if (!w_empty) begin
      m_if.m_data = r_mem[r_rd_ptr];
    end else begin
      m_if.m_data = {DATA_WIDTH{1'b0}};
    end
  end

  assign o_full       = w_full;
  assign o_empty      = w_empty;
  assign o_level      = r_level;
  assign o_overflow   = r_overflow;
  assign o_drop_count = r_drop_count;
endmodule

// File: tb/tb_fir_out_buffer.sv
// Directed self-checking bench for fir_out_buffer (built with a 4-bit drop counter).
module tb_fir_out_buffer;
  localparam int DW = 16;
  localparam int DEPTH = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic          full;
  logic          empty;
  logic [3:0]    level;
  logic          overflow;
  logic [CW-1:0] drop_count;
  logic          clear_ovf;

  int n_checks = 0;
  int n_fails  = 0;

  fir_out_buffer_if #(.DATA_WIDTH(DW)) m_if ();

  fir_out_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid_in   (valid_in),
    .i_data_in    (data_in),
    .m_if         (m_if.master),
    .o_full       (full),
    .o_empty      (empty),
    .o_level      (level),
    .o_overflow   (overflow),
    .o_drop_count (drop_count),
    .i_clear_ovf  (clear_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int first);
    for (int i = 0; i < DEPTH; i++) begin
      valid_in = 1'b1;
      data_in  = DW'(first + i);
      step();
    end
    valid_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; data_in = '0; clear_ovf = 1'b0; m_if.m_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_mvalid", 32'(m_if.m_valid), 32'd0);
    check("rst_mdata", 32'(m_if.m_data), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);

    // Fill 1..8 with no reader
    fill(1);
    check("fill_level", 32'(level), 32'd8);
    check("fill_full", 32'(full), 32'd1);
    check("fill_mvalid", 32'(m_if.m_valid), 32'd1);
    check("fill_mdata", 32'(m_if.m_data), 32'd1);
    check("fill_ovf", 32'(overflow), 32'd0);

    // Push into full with no pop -> drop
    valid_in = 1'b1; data_in = 16'd9; step(); valid_in = 1'b0;
    check("drop_ovf", 32'(overflow), 32'd1);
    check("drop_cnt", 32'(drop_count), 32'd1);
    check("drop_level", 32'(level), 32'd8);
    m_if.m_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      check("drain1_data", 32'(m_if.m_data), 32'(k));
      step();
    end
    m_if.m_ready = 1'b0;
    check("drain1_empty", 32'(empty), 32'd1);
    check("drain1_mvalid", 32'(m_if.m_valid), 32'd0);
    check("drain1_mdata0", 32'(m_if.m_data), 32'd0);
    clear_ovf = 1'b1; step(); clear_ovf = 1'b0;
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_cnt", 32'(drop_count), 32'd0);

    // Full with simultaneous pop and push -> accepted
    fill(1);
    valid_in = 1'b1; data_in = 16'd9; m_if.m_ready = 1'b1; step(); valid_in = 1'b0;
    check("fpp_level", 32'(level), 32'd8);
    check("fpp_ovf", 32'(overflow), 32'd0);
    check("fpp_cnt", 32'(drop_count), 32'd0);
    for (int k = 2; k <= 9; k++) begin
      check("drain2_data", 32'(m_if.m_data), 32'(k));
      step();
    end
    check("drain2_empty", 32'(empty), 32'd1);

    // Passthrough 5,6,7 with m_ready held high
    for (int k = 5; k <= 7; k++) begin
      valid_in = 1'b1; data_in = DW'(k); step();
      check("pt_mvalid", 32'(m_if.m_valid), 32'd1);
      check("pt_mdata", 32'(m_if.m_data), 32'(k));
      check("pt_level", 32'(level), 32'd1);
    end
    valid_in = 1'b0; step();
    check("pt_empty", 32'(empty), 32'd1);
    m_if.m_ready = 1'b0;

    // Drop counter saturation and clear/drop collision
    fill(1);
    valid_in = 1'b1; data_in = 16'hBEEF;
    for (int i = 0; i < 20; i++) step();
    check("sat_cnt", 32'(drop_count), 32'd15);
    check("sat_ovf", 32'(overflow), 32'd1);
    check("sat_level", 32'(level), 32'd8);
    check("sat_head", 32'(m_if.m_data), 32'd1);
    clear_ovf = 1'b1; step();
    check("clrdrop_ovf", 32'(overflow), 32'd1);
    check("clrdrop_cnt", 32'(drop_count), 32'd1);
    valid_in = 1'b0; step(); clear_ovf = 1'b0;
    check("clronly_ovf", 32'(overflow), 32'd0);
    check("clronly_cnt", 32'(drop_count), 32'd0);

    // Reset mid-operation discards contents and flags
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      valid_in = 1'b1; data_in = DW'(100 + i); step();
    end
    valid_in = 1'b0;
    check("ld5_level", 32'(level), 32'd5);
    fill(200);
    valid_in = 1'b1; data_in = 16'd77; step(); valid_in = 1'b0;
    check("ld_drop_ovf", 32'(overflow), 32'd1);
    rst = 1'b1; valid_in = 1'b1; data_in = 16'd55; step(); rst = 1'b0; valid_in = 1'b0;
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_mvalid", 32'(m_if.m_valid), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    check("mid_rst_cnt", 32'(drop_count), 32'd0);
    valid_in = 1'b1; data_in = 16'd42; step(); valid_in = 1'b0;
    check("post_rst_mvalid", 32'(m_if.m_valid), 32'd1);
    check("post_rst_mdata", 32'(m_if.m_data), 32'd42);
    check("post_rst_level", 32'(level), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end
endmodule
